// File: rtl/lfo_axi_lite_if.sv
// AXI4-Lite bus bundle between the block-design interconnect and the LFO register block.
`timescale 1ns/1ps
interface lfo_axi_lite_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR;
   logic [2:0]                        AWPROT;
   logic                              AWVALID;
   logic                              AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB;
   logic                              WVALID;
   logic                              WREADY;
   logic [1:0]                        BRESP;
   logic                              BVALID;
   logic                              BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR;
   logic [2:0]                        ARPROT;
   logic                              ARVALID;
   logic                              ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA;
   logic [1:0]                        RRESP;
   logic                              RVALID;
   logic                              RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/lfo_axi_lite_regs.sv
// AXI4-Lite responder holding the four LFO control registers; write and read paths
// run as independent state machines, each with one transaction in flight.
`timescale 1ns/1ps
module lfo_axi_lite_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   lfo_axi_lite_if.slave                 s_axi,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_ctrl,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_phase_inc,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_wave_sel,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_amplitude,
   output logic [3:0]                    reg_wr_stb
);
   localparam int DataW    = C_S_AXI_DATA_WIDTH;
   localparam int NumBytes = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wState_e;
   typedef enum logic {R_IDLE, R_DATA} rState_e;

   wState_e             wState_q;
   rState_e             rState_q;
   logic                awReady_q;
   logic                wReady_q;
   logic                bValid_q;
   logic                arReady_q;
   logic                rValid_q;
   logic [1:0]          awIdx_q;
   logic [DataW-1:0]    wData_q;
   logic [NumBytes-1:0] wStrb_q;
   logic [DataW-1:0]    rData_q;
   logic [DataW-1:0]    regs_q [4];
   logic [DataW-1:0]    regs_d [4];
   logic [3:0]          wrStb_q;
   logic [3:0]          wrStb_d;

   logic                awHs;
   logic                wHs;
   logic                arHs;
   logic                commitEn;
   logic [1:0]          commitIdx;
   logic [DataW-1:0]    commitData;
   logic [NumBytes-1:0] commitStrb;
   logic                unusedBits;

   assign awHs = s_axi.AWVALID & awReady_q;
   assign wHs  = s_axi.WVALID & wReady_q;
   assign arHs = s_axi.ARVALID & arReady_q;

   assign unusedBits = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

   // The commit takes address and data from the bus or from whichever half was latched earlier.
   always_comb begin
      commitEn   = 1'b0;
      commitIdx  = s_axi.AWADDR[3:2];
      commitData = s_axi.WDATA;
      commitStrb = s_axi.WSTRB;
      case (wState_q)
         W_IDLE:    commitEn = awHs & wHs;
         W_HAVE_AW: begin
            commitEn  = wHs;
            commitIdx = awIdx_q;
         end
         W_HAVE_W:  begin
            commitEn   = awHs;
            commitData = wData_q;
            commitStrb = wStrb_q;
         end
         default:   commitEn = 1'b0;
      endcase
   end

   always_comb begin
      regs_d  = regs_q;
      wrStb_d = '0;
      if (commitEn) begin
         wrStb_d[commitIdx] = 1'b1;
         for (int b = 0; b < NumBytes; b++) begin
            if (commitStrb[b]) begin
               regs_d[commitIdx][8*b +: 8] = commitData[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         regs_q  <= '{default: '0};
         wrStb_q <= '0;
      end else begin
         regs_q  <= regs_d;
         wrStb_q <= wrStb_d;
      end
   end

   // Readies stay low through reset and rise on the first clock after release.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wState_q  <= W_IDLE;
         awReady_q <= 1'b0;
         wReady_q  <= 1'b0;
         bValid_q  <= 1'b0;
         awIdx_q   <= '0;
         wData_q   <= '0;
         wStrb_q   <= '0;
      end else begin
         case (wState_q)
            W_IDLE: begin
               if (awHs && wHs) begin
                  awReady_q <= 1'b0;
                  wReady_q  <= 1'b0;
                  bValid_q  <= 1'b1;
                  wState_q  <= W_RESP;
               end else if (awHs) begin
                  awIdx_q   <= s_axi.AWADDR[3:2];
                  awReady_q <= 1'b0;
                  wReady_q  <= 1'b1;
                  wState_q  <= W_HAVE_AW;
               end else if (wHs) begin
                  wData_q   <= s_axi.WDATA;
                  wStrb_q   <= s_axi.WSTRB;
                  awReady_q <= 1'b1;
                  wReady_q  <= 1'b0;
                  wState_q  <= W_HAVE_W;
               end else begin
                  awReady_q <= 1'b1;
                  wReady_q  <= 1'b1;
               end
            end
            W_HAVE_AW: begin
               if (wHs) begin
                  wReady_q <= 1'b0;
                  bValid_q <= 1'b1;
                  wState_q <= W_RESP;
               end
            end
            W_HAVE_W: begin
               if (awHs) begin
                  awReady_q <= 1'b0;
                  bValid_q  <= 1'b1;
                  wState_q  <= W_RESP;
               end
            end
            W_RESP: begin
               if (s_axi.BREADY) begin
                  bValid_q  <= 1'b0;
                  awReady_q <= 1'b1;
                  wReady_q  <= 1'b1;
                  wState_q  <= W_IDLE;
               end
            end
            default: wState_q <= W_IDLE;
         endcase
      end
   end

   // Read data is sampled from the pre-commit register value, so a same-cycle write is not seen.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rState_q  <= R_IDLE;
         arReady_q <= 1'b0;
         rValid_q  <= 1'b0;
         rData_q   <= '0;
      end else begin
         case (rState_q)
            R_IDLE: begin
               if (arHs) begin
                  rData_q   <= regs_q[s_axi.ARADDR[3:2]];
                  rValid_q  <= 1'b1;
                  arReady_q <= 1'b0;
                  rState_q  <= R_DATA;
               end else begin
                  arReady_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi.RREADY) begin
                  rValid_q  <= 1'b0;
                  arReady_q <= 1'b1;
                  rState_q  <= R_IDLE;
               end
            end
            default: rState_q <= R_IDLE;
         endcase
      end
   end

   assign s_axi.AWREADY = awReady_q;
   assign s_axi.WREADY  = wReady_q;
   assign s_axi.BVALID  = bValid_q;
   assign s_axi.BRESP   = 2'b00;
   assign s_axi.ARREADY = arReady_q;
   assign s_axi.RVALID  = rValid_q;
   assign s_axi.RDATA   = rData_q;
   assign s_axi.RRESP   = 2'b00;

   assign reg0_ctrl      = regs_q[0];
   assign reg1_phase_inc = regs_q[1];
   assign reg2_wave_sel  = regs_q[2];
   assign reg3_amplitude = regs_q[3];
   assign reg_wr_stb     = wrStb_q;
endmodule

// File: tb/tb_lfo_axi_lite_regs.sv
// Directed testbench for lfo_axi_lite_regs: drives the AXI4-Lite bus through the
// interface and compares every observation against hand-computed values.
`timescale 1ns/1ps
module tb_lfo_axi_lite_regs;
   logic        ACLK;
   logic        ARESETN;
   logic [31:0] reg0_ctrl;
   logic [31:0] reg1_phase_inc;
   logic [31:0] reg2_wave_sel;
   logic [31:0] reg3_amplitude;
   logic [3:0]  reg_wr_stb;

   int vectors;
   int miscompares;

   lfo_axi_lite_if bus ();

   lfo_axi_lite_regs dut (
      .ACLK           (ACLK),
      .ARESETN        (ARESETN),
      .s_axi          (bus),
      .reg0_ctrl      (reg0_ctrl),
      .reg1_phase_inc (reg1_phase_inc),
      .reg2_wave_sel  (reg2_wave_sel),
      .reg3_amplitude (reg3_amplitude),
      .reg_wr_stb     (reg_wr_stb)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Global time bound so a stuck bus can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Full AXI write with BREADY high; checks latency, response and strobe pulse.
   task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic awAcc, wAcc, awDone, wDone;
      logic [3:0] expStb;
      expStb = 4'b0001 << addr[3:2];
      awDone = 1'b0;
      wDone  = 1'b0;
      bus.AWADDR  = addr;
      bus.WDATA   = data;
      bus.WSTRB   = strb;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      bus.BREADY  = 1'b1;
      for (int cyc = 0; cyc < 20 && !(awDone && wDone); cyc++) begin
         awAcc = bus.AWVALID & bus.AWREADY;
         wAcc  = bus.WVALID & bus.WREADY;
         @(posedge ACLK); #1;
         if (awAcc) begin
            bus.AWVALID = 1'b0;
            awDone = 1'b1;
         end
         if (wAcc) begin
            bus.WVALID = 1'b0;
            wDone = 1'b1;
         end
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      checkOutput("write accepted", {31'd0, awDone & wDone}, 32'd1);
      if (awDone && wDone) begin
         checkOutput("bvalid latency", {31'd0, bus.BVALID}, 32'd1);
         checkOutput("bresp", {30'd0, bus.BRESP}, 32'd0);
         checkOutput("wr stb pulse", {28'd0, reg_wr_stb}, {28'd0, expStb});
         @(posedge ACLK); #1;
         checkOutput("bvalid drop", {31'd0, bus.BVALID}, 32'd0);
         checkOutput("wr stb clear", {28'd0, reg_wr_stb}, 32'd0);
      end
   endtask

   task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
      logic arAcc, done;
      done = 1'b0;
      data = '0;
      bus.ARADDR  = addr;
      bus.ARVALID = 1'b1;
      bus.RREADY  = 1'b1;
      for (int cyc = 0; cyc < 20 && !done; cyc++) begin
         arAcc = bus.ARREADY;
         @(posedge ACLK); #1;
         if (arAcc) done = 1'b1;
      end
      bus.ARVALID = 1'b0;
      checkOutput("read accepted", {31'd0, done}, 32'd1);
      if (done) begin
         checkOutput("rvalid latency", {31'd0, bus.RVALID}, 32'd1);
         checkOutput("rresp", {30'd0, bus.RRESP}, 32'd0);
         data = bus.RDATA;
         @(posedge ACLK); #1;
         checkOutput("rvalid drop", {31'd0, bus.RVALID}, 32'd0);
      end
   endtask

   logic [31:0] rd;
   logic [31:0] seqData [4];

   initial begin
      vectors     = 0;
      miscompares = 0;
      seqData     = '{32'h1, 32'h2, 32'h3, 32'h4};
      ARESETN     = 1'b0;
      bus.AWADDR  = '0;
      bus.AWPROT  = '0;
      bus.AWVALID = 1'b0;
      bus.WDATA   = '0;
      bus.WSTRB   = '0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b0;
      bus.ARADDR  = '0;
      bus.ARPROT  = '0;
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b0;

      // Reset held for 200 ns; release lands on a falling edge.
      #100;
      checkOutput("rst awready", {31'd0, bus.AWREADY}, 32'd0);
      checkOutput("rst wready", {31'd0, bus.WREADY}, 32'd0);
      checkOutput("rst arready", {31'd0, bus.ARREADY}, 32'd0);
      checkOutput("rst bvalid", {31'd0, bus.BVALID}, 32'd0);
      checkOutput("rst rvalid", {31'd0, bus.RVALID}, 32'd0);
      checkOutput("rst rdata", bus.RDATA, 32'd0);
      checkOutput("rst stb", {28'd0, reg_wr_stb}, 32'd0);
      checkOutput("rst regs", reg0_ctrl | reg1_phase_inc | reg2_wave_sel | reg3_amplitude, 32'd0);
      #100;
      ARESETN = 1'b1;
      checkOutput("release awready pre", {31'd0, bus.AWREADY}, 32'd0);
      @(posedge ACLK); #1;
      checkOutput("release awready", {31'd0, bus.AWREADY}, 32'd1);
      checkOutput("release wready", {31'd0, bus.WREADY}, 32'd1);
      checkOutput("release arready", {31'd0, bus.ARREADY}, 32'd1);

      // Sequential writes then reads of all four registers.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'(i * 4), seqData[i], 4'hF);
      end
      checkOutput("reg0 out", reg0_ctrl, 32'h1);
      checkOutput("reg1 out", reg1_phase_inc, 32'h2);
      checkOutput("reg2 out", reg2_wave_sel, 32'h3);
      checkOutput("reg3 out", reg3_amplitude, 32'h4);
      for (int i = 0; i < 4; i++) begin
         readReg(4'(i * 4), rd);
         checkOutput("seq read", rd, seqData[i]);
      end

      // Byte strobes.
      applyStimulus(4'h4, 32'hFFFF_FFFF, 4'hF);
      applyStimulus(4'h4, 32'h1234_5678, 4'b0101);
      readReg(4'h4, rd);
      checkOutput("byte strobe read", rd, 32'hFF34_FF78);
      applyStimulus(4'h7, 32'hDEAD_BEEF, 4'b0000);
      checkOutput("zero strobe keeps", reg1_phase_inc, 32'hFF34_FF78);

      // W arrives three cycles ahead of AW.
      bus.WDATA  = 32'hA5A5_A5A5;
      bus.WSTRB  = 4'hF;
      bus.WVALID = 1'b1;
      bus.BREADY = 1'b1;
      checkOutput("wfirst wready pre", {31'd0, bus.WREADY}, 32'd1);
      @(posedge ACLK); #1;
      bus.WVALID = 1'b0;
      checkOutput("wfirst wready drop", {31'd0, bus.WREADY}, 32'd0);
      checkOutput("wfirst awready", {31'd0, bus.AWREADY}, 32'd1);
      checkOutput("wfirst no bvalid", {31'd0, bus.BVALID}, 32'd0);
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      bus.AWADDR  = 4'h8;
      bus.AWVALID = 1'b1;
      @(posedge ACLK); #1;
      bus.AWVALID = 1'b0;
      checkOutput("wfirst bvalid", {31'd0, bus.BVALID}, 32'd1);
      checkOutput("wfirst reg2", reg2_wave_sel, 32'hA5A5_A5A5);
      checkOutput("wfirst stb", {28'd0, reg_wr_stb}, 32'h4);
      @(posedge ACLK); #1;
      checkOutput("wfirst bvalid drop", {31'd0, bus.BVALID}, 32'd0);

      // Write-response backpressure with a second write waiting on the bus.
      bus.BREADY  = 1'b0;
      bus.AWADDR  = 4'h0;
      bus.WDATA   = 32'h0000_0055;
      bus.WSTRB   = 4'hF;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      @(posedge ACLK); #1;
      bus.AWADDR = 4'h4;
      bus.WDATA  = 32'h0000_0077;
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp bvalid hold", {31'd0, bus.BVALID}, 32'd1);
         checkOutput("bp ready low", {30'd0, bus.AWREADY, bus.WREADY}, 32'd0);
         @(posedge ACLK); #1;
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      checkOutput("bp reg0", reg0_ctrl, 32'h55);
      checkOutput("bp reg1 untouched", reg1_phase_inc, 32'hFF34_FF78);
      bus.BREADY = 1'b1;
      @(posedge ACLK); #1;
      checkOutput("bp bvalid drop", {31'd0, bus.BVALID}, 32'd0);

      // Read-data backpressure.
      bus.ARADDR  = 4'h0;
      bus.ARVALID = 1'b1;
      bus.RREADY  = 1'b0;
      @(posedge ACLK); #1;
      bus.ARVALID = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checkOutput("rbp rvalid hold", {31'd0, bus.RVALID}, 32'd1);
         checkOutput("rbp rdata hold", bus.RDATA, 32'h55);
         checkOutput("rbp arready low", {31'd0, bus.ARREADY}, 32'd0);
         @(posedge ACLK); #1;
      end
      bus.RREADY = 1'b1;
      @(posedge ACLK); #1;
      checkOutput("rbp rvalid drop", {31'd0, bus.RVALID}, 32'd0);

      // Same-cycle read and write to 0xC.
      bus.AWADDR  = 4'hC;
      bus.WDATA   = 32'h0000_0099;
      bus.WSTRB   = 4'hF;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      bus.BREADY  = 1'b1;
      bus.ARADDR  = 4'hC;
      bus.ARVALID = 1'b1;
      bus.RREADY  = 1'b1;
      @(posedge ACLK); #1;
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      bus.ARVALID = 1'b0;
      checkOutput("coll rvalid", {31'd0, bus.RVALID}, 32'd1);
      checkOutput("coll old data", bus.RDATA, 32'h4);
      checkOutput("coll bvalid", {31'd0, bus.BVALID}, 32'd1);
      checkOutput("coll reg3", reg3_amplitude, 32'h99);
      @(posedge ACLK); #1;
      readReg(4'hC, rd);
      checkOutput("coll new data", rd, 32'h99);

      // Reset asserted while BVALID is pending.
      bus.BREADY  = 1'b0;
      bus.AWADDR  = 4'h0;
      bus.WDATA   = 32'h0000_1234;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      @(posedge ACLK); #1;
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      checkOutput("mid bvalid set", {31'd0, bus.BVALID}, 32'd1);
      #2;
      ARESETN = 1'b0;
      #1;
      checkOutput("mid rst bvalid", {31'd0, bus.BVALID}, 32'd0);
      checkOutput("mid rst awready", {31'd0, bus.AWREADY}, 32'd0);
      checkOutput("mid rst regs", reg0_ctrl | reg1_phase_inc | reg2_wave_sel | reg3_amplitude, 32'd0);
      bus.BREADY = 1'b1;
      #10;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      for (int i = 0; i < 4; i++) begin
         readReg(4'(i * 4), rd);
         checkOutput("post rst read", rd, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
